// File: rtl/adder_pkg.sv
// Shared sizing constants for the carry-lookahead adder.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
package adder_pkg;

    localparam int ADDER_WIDTH  = 16;
    localparam int CLA_GROUP    = 4;
    localparam int ADDER_GROUPS = ADDER_WIDTH / CLA_GROUP;

    // Number of 4-bit lookahead groups needed for an operand of the given width.
    function automatic int groupCount(input int width);
        return width / CLA_GROUP;
    endfunction

endpackage : adder_pkg

// File: rtl/adder_if.sv
// Operand/result bundle for the adder, for benches and wrappers driving it.
// Latency: n/a (wiring only).
// Backpressure: none; the adder accepts a new operand pair on every edge.
interface adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
);

    logic [WIDTH-1:0] OperandoA;
    logic [WIDTH-1:0] OperandoB;
    logic [WIDTH:0]   Soma;

    // Operand source side.
    modport master (
        output OperandoA,
        output OperandoB,
        input  Soma
    );

    // Adder side.
    modport slave (
        input  OperandoA,
        input  OperandoB,
        output Soma
    );

endinterface : adder_if

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead group: sum plus group propagate/generate for the next level.
// Latency: purely combinational.
// Backpressure: none.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carryIn,
    output logic [3:0] sum,
    output logic       groupProp,
    output logic       groupGen
);

    logic [3:0] bitProp;
    logic [3:0] bitGen;
    logic [3:0] carry;

    // Bit-level propagate/generate, in-group carries in flattened lookahead form, and group terms.
    always_comb begin
        bitProp  = a ^ b;
        bitGen   = a & b;
        carry[0] = carryIn;
        carry[1] = bitGen[0] | (bitProp[0] & carryIn);
        carry[2] = bitGen[1] | (bitProp[1] & bitGen[0])
                 | (bitProp[1] & bitProp[0] & carryIn);
        carry[3] = bitGen[2] | (bitProp[2] & bitGen[1])
                 | (bitProp[2] & bitProp[1] & bitGen[0])
                 | (bitProp[2] & bitProp[1] & bitProp[0] & carryIn);
        sum       = bitProp ^ carry;
        groupProp = &bitProp;
        groupGen  = bitGen[3] | (bitProp[3] & bitGen[2])
                  | (bitProp[3] & bitProp[2] & bitGen[1])
                  | (bitProp[3] & bitProp[2] & bitProp[1] & bitGen[0]);
    end

endmodule : cla4

// File: rtl/adder.sv
// Registered unsigned adder built from 4-bit CLA groups and a second-level lookahead unit.
// Latency: 1 cycle from operands to Soma; one new pair accepted every edge.
// Backpressure: none; there is no handshake and the adder never stalls.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] OperandoA,
    input  logic [WIDTH-1:0] OperandoB,
    output logic [WIDTH:0]   Soma
);

    localparam int GROUPS = groupCount(WIDTH);

    if (WIDTH % CLA_GROUP != 0) begin : gWidthCheck
        $error("adder: WIDTH must be a multiple of 4");
    end

    logic [GROUPS-1:0] groupP;
    logic [GROUPS-1:0] groupG;
    // groupCarry[i] is the carry into group i; the top bit is the final carry-out.
    logic [GROUPS:0]   groupCarry;
    logic [WIDTH-1:0]  sumBits;
    logic              prodP;

    for (genvar gi = 0; gi < GROUPS; gi++) begin : gGroup
        cla4 uCla4 (
            .a         (OperandoA[CLA_GROUP*gi +: CLA_GROUP]),
            .b         (OperandoB[CLA_GROUP*gi +: CLA_GROUP]),
            .carryIn   (groupCarry[gi]),
            .sum       (sumBits[CLA_GROUP*gi +: CLA_GROUP]),
            .groupProp (groupP[gi]),
            .groupGen  (groupG[gi])
        );
    end

    // Second-level lookahead: each group carry is the OR of every lower group's generate
    // gated by the propagates between it and the target, so no carry ripples group to group.
    // There is no carry-in, so groupCarry[0] is tied low.
    always_comb begin
        groupCarry = '0;
        prodP      = 1'b1;
        for (int i = 1; i <= GROUPS; i++) begin
            for (int j = 0; j < i; j++) begin
                prodP = 1'b1;
                for (int k = j + 1; k < i; k++) begin
                    prodP = prodP & groupP[k];
                end
                groupCarry[i] = groupCarry[i] | (groupG[j] & prodP);
            end
        end
    end

    // Output register; reset wins over the addition on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            Soma <= '0;
        end else begin
            Soma <= {groupCarry[GROUPS], sumBits};
        end
    end

endmodule : adder

// File: tb/tb_adder.sv
// Scoreboard bench for the registered CLA adder: driver queues expected sums, monitor checks.
// Latency: expects each result one edge after its operands.
// Backpressure: none; operands change every cycle.
module tb_adder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [16:0] expQ[$];
    string       nameQ[$];
    logic [16:0] lastExp;
    bit          haveLast;

    adder_if #(.WIDTH(16)) bus ();

    adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .OperandoA (bus.OperandoA),
        .OperandoB (bus.OperandoB),
        .Soma      (bus.Soma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand pair for the coming edge and queue what the adder must show after it.
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic r,
                         input string nm);
        logic [16:0] e;
        @(negedge clk);
        bus.OperandoA = a;
        bus.OperandoB = b;
        rst           = r;
        e = r ? 17'd0 : (17'(a) + 17'(b));
        expQ.push_back(e);
        nameQ.push_back(nm);
    endtask

    // Result monitor: after each rising edge, pop the queued expectation and compare.
    initial begin
        logic [16:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e  = expQ.pop_front();
                nm = nameQ.pop_front();
                checks++;
                if (bus.Soma !== e) begin
                    failures++;
                    $display("FAIL %s: Soma=%05h required=%05h", nm, bus.Soma, e);
                end
                lastExp  = e;
                haveLast = 1'b1;
            end
        end
    end

    // Hold monitor: after the inputs change mid-cycle, the output must not move.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (haveLast) begin
                checks++;
                if (bus.Soma !== lastExp) begin
                    failures++;
                    $display("FAIL hold: Soma=%05h required=%05h", bus.Soma, lastExp);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: run time exceeded");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic        r;
        checks        = 0;
        failures      = 0;
        haveLast      = 1'b0;
        lastExp       = '0;
        rst           = 1'b1;
        bus.OperandoA = '0;
        bus.OperandoB = '0;

        // Reset with nonzero operands present: result must be discarded.
        drive(16'h1357, 16'h2468, 1'b1, "reset0");
        drive(16'hFFFF, 16'hFFFF, 1'b1, "reset1");
        // Directed cases.
        drive(16'h0000, 16'h0000, 1'b0, "zero");
        drive(16'hFFFF, 16'h0001, 1'b0, "ripple_all");
        drive(16'hFFFF, 16'hFFFF, 1'b0, "max");
        drive(16'h1234, 16'h4321, 1'b0, "b2b_second");
        drive(16'h8000, 16'h8000, 1'b1, "reset_prio");
        drive(16'h8000, 16'h8000, 1'b0, "after_reset");
        drive(16'hAAAA, 16'h5555, 1'b0, "alt_bits");
        drive(16'h000F, 16'h0001, 1'b0, "group0_carry");
        drive(16'h0FFF, 16'h0001, 1'b0, "group2_carry");
        drive(16'hFFFF, 16'h0000, 1'b0, "all_prop_no_gen");
        drive(16'h7FFF, 16'h8000, 1'b0, "no_carry_out");

        // Random pairs, each held for 40 ns (four edges).
        for (int n = 0; n < 16; n++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            for (int h = 0; h < 4; h++) begin
                drive(a, b, 1'b0, "rand_hold");
            end
        end

        // Random pairs every edge with occasional reset.
        for (int n = 0; n < 120; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            r = ($urandom_range(0, 15) == 0);
            drive(a, b, r, "rand_stream");
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adder
